// File: rtl/nogtx_tx_pkg.sv
// Shared definitions for the no-GTX transmit serializer: mode encodings,
// idle word default and PRBS7 generator helpers.
package nogtx_tx_pkg;

  typedef enum logic [1:0] {
    MODE_DATA  = 2'd0,
    MODE_IDLE  = 2'd1,
    MODE_CNT   = 2'd2,
    MODE_PRBS7 = 2'd3
  } tx_mode_e;

  localparam logic [7:0] IDLE_WORD_DEFAULT = 8'h3C;

  // x^7 + x^6 + 1: feedback is the XOR of the two oldest state bits
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

  function automatic logic [6:0] prbs7_advance(input logic [6:0] s, input int unsigned n);
    logic [6:0] st;
    st = s;
    for (int i = 0; i < 16; i++) begin
      if (i < n) st = prbs7_step(st);
    end
    return st;
  endfunction

  // The first generated bit lands in bit 0 so it is shifted out first
  function automatic logic [7:0] prbs7_byte(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] b;
    st = s;
    b  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      st   = prbs7_step(st);
      b[i] = st[0];
    end
    return b;
  endfunction

endpackage

// File: rtl/nogtx_tx_fifo.sv
// Small word FIFO feeding the serializer; full/empty are registered so the
// upstream ready never depends combinationally on the pop side.
module nogtx_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk320,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + 1'b1;
    else if (!push_ok && pop_ok) count_next = count - 1'b1;
  end

  always_ff @(posedge clk320) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/nogtx_data_serializer.sv
// Byte-to-serial transmitter for the 320 Mbps no-GTX link: LSB-first shift-out
// of FIFO data, idle, counter or PRBS7 words with polarity and bit delay.
module nogtx_data_serializer
  import nogtx_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_WORD  = IDLE_WORD_DEFAULT
) (
  input  logic        clk320,
  input  logic        rstn,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        polarity,
  input  logic [3:0]  bit_latency,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        sout,
  output logic        frame_start,
  output logic [15:0] idle_count
);

  logic [2:0]  bit_cnt;
  logic        load_edge;
  logic [7:0]  shreg;
  logic [7:0]  next_word;
  logic [7:0]  cnt8;
  logic [6:0]  lfsr;
  logic        disabled_word;
  logic        serial_bit;
  logic [14:0] history;
  logic [15:0] idle_cnt;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  assign load_edge   = (bit_cnt == 3'd7);
  assign fifo_pop    = load_edge && enable && (mode == MODE_DATA);
  assign din_ready   = !fifo_full;
  assign frame_start = rstn && (bit_cnt == 3'd0);
  assign serial_bit  = disabled_word ? 1'b0 : (shreg[0] ^ polarity);
  assign idle_count  = idle_cnt;

  nogtx_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk320    (clk320),
    .rstn      (rstn),
    .push      (din_valid),
    .push_data (din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    next_word = 8'h00;
    if (enable) begin
      case (tx_mode_e'(mode))
        MODE_DATA:  next_word = fifo_empty ? IDLE_WORD : fifo_dout;
        MODE_IDLE:  next_word = IDLE_WORD;
        MODE_CNT:   next_word = cnt8;
        MODE_PRBS7: next_word = prbs7_byte(lfsr);
        default:    next_word = 8'h00;
      endcase
    end
  end

  // Word framing: a new word enters at the end of bit 7, otherwise shift right
  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      disabled_word <= 1'b0;
      cnt8          <= 8'h00;
      lfsr          <= PRBS7_SEED;
      idle_cnt      <= 16'h0000;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load_edge) begin
        shreg         <= next_word;
        disabled_word <= !enable;
        if (enable) begin
          case (tx_mode_e'(mode))
            MODE_DATA: begin
              if (fifo_empty && (idle_cnt != 16'hFFFF)) idle_cnt <= idle_cnt + 16'd1;
            end
            MODE_CNT:   cnt8 <= cnt8 + 8'd1;
            MODE_PRBS7: lfsr <= prbs7_advance(lfsr, 8);
            default: ;
          endcase
        end
      end else begin
        shreg <= {1'b0, shreg[7:1]};
      end
    end
  end

  // history[i] holds the serial bit from i+1 cycles ago
  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      history <= 15'h0000;
      sout    <= 1'b0;
    end else begin
      history <= {history[13:0], serial_bit};
      sout    <= (bit_latency == 4'd0) ? serial_bit : history[bit_latency - 4'd1];
    end
  end

endmodule
